ram512_arb: RTL and testbench

RAM512_ARB -- requirements
Module: ram512_arb

---
 rtl/ram512_arb_pkg.sv | 22 ++
 rtl/ram512_arb_if.sv | 43 ++++
 rtl/ram512_arb_rr.sv | 23 ++
 rtl/ram512_arb.sv | 85 ++++++++
 tb/tb_ram512_arb.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/ram512_arb_pkg.sv
// ram512_arb shared types: widths, FSM state, latched command.
// Optional define RAM512_ARB_FIXED_PRIO_EN selects fixed priority.
package ram512_arb_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  typedef logic port_t;

  typedef struct packed {
    port_t             port;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/ram512_arb_if.sv
// ram512_arb bus: two request ports plus the RAM512 side.
// slave = arbiter view, master = requester/RAM view.
interface ram512_arb_if;
  import ram512_arb_pkg::*;

  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] ram_in;
  logic              ram_load;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_out;

  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    input  ram_out,
    output gnt0, gnt1, ack0, ack1,
    output rdata0, rdata1,
    output ram_in, ram_load, ram_address
  );

  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    output ram_out,
    input  gnt0, gnt1, ack0, ack1,
    input  rdata0, rdata1,
    input  ram_in, ram_load, ram_address
  );

endinterface

// File: rtl/ram512_arb_rr.sv
// ram512_arb tie-break: round-robin on last_grant, or fixed
// priority to port 0 when RAM512_ARB_FIXED_PRIO_EN is defined.
module ram512_arb_rr
  import ram512_arb_pkg::*;
(
  input  logic  req0,
  input  logic  req1,
  input  port_t last_grant,
  output logic  winner0,
  output logic  winner1
);

`ifdef RAM512_ARB_FIXED_PRIO_EN
  logic unused_lg;
  assign unused_lg = last_grant;
  assign winner0   = req0;
  assign winner1   = req1 & ~req0;
`else
  assign winner0 = req0 & (~req1 | last_grant);
  assign winner1 = req1 & (~req0 | ~last_grant);
`endif

endmodule

// File: rtl/ram512_arb.sv
// ram512_arb: two-port arbiter in front of a RAM512.
// Grant in IDLE, drive RAM in ACCESS, ack the cycle after.
module ram512_arb
  import ram512_arb_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  ram512_arb_if.slave bus
);

  state_t            state;
  state_t            state_nx;
  cmd_t              cmd;
  port_t             last_grant;
  logic              win0;
  logic              win1;
  logic              gnt0;
  logic              gnt1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;

  ram512_arb_rr u_rr (
    .req0       (bus.req0),
    .req1       (bus.req1),
    .last_grant (last_grant),
    .winner0    (win0),
    .winner1    (win1)
  );

  always_comb begin
    state_nx = state;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    unique case (state)
      IDLE: begin
        gnt0 = bus.req0 & win0;
        gnt1 = bus.req1 & win1;
        if (gnt0 | gnt1) state_nx = ACCESS;
      end
      ACCESS: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd        <= '0;
      last_grant <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      state <= state_nx;
      ack0  <= (state == ACCESS) && (cmd.port == 1'b0);
      ack1  <= (state == ACCESS) && (cmd.port == 1'b1);
      if (gnt0 | gnt1) begin
        cmd.port   <= gnt1;
        cmd.we     <= gnt1 ? bus.we1 : bus.we0;
        cmd.addr   <= gnt1 ? bus.addr1 : bus.addr0;
        cmd.wdata  <= gnt1 ? bus.wdata1 : bus.wdata0;
        last_grant <= gnt1;
      end
      // read data lands at the edge closing ACCESS
      if (state == ACCESS && !cmd.we) begin
        if (cmd.port) rdata1 <= bus.ram_out;
        else          rdata0 <= bus.ram_out;
      end
    end
  end

  assign bus.gnt0        = gnt0;
  assign bus.gnt1        = gnt1;
  assign bus.ack0        = ack0;
  assign bus.ack1        = ack1;
  assign bus.rdata0      = rdata0;
  assign bus.rdata1      = rdata1;
  assign bus.ram_load    = (state == ACCESS) & cmd.we;
  assign bus.ram_address = cmd.addr;
  assign bus.ram_in      = cmd.wdata;

endmodule

// File: tb/tb_ram512_arb.sv
// ram512_arb bench: RAM512 model, scoreboard of expected acks,
// directed latency / arbitration / reset-abort sequences.
module tb_ram512_arb;
  import ram512_arb_pkg::*;

  typedef struct {
    bit          port;
    bit          rd;
    logic [15:0] data;
  } sb_t;

  logic clk;
  logic rst_n;
  bit   mem_clr;
  int   npass;
  int   ntot;
  bit   lg;
  sb_t  sb[$];
  sb_t  e;

  logic [15:0] ram[512];
  logic [15:0] exp_mem[512];

  ram512_arb_if bus ();

  ram512_arb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.ram_out = ram[bus.ram_address[8:0]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 512; i++) ram[i] <= '0;
    end else if (bus.ram_load) begin
      ram[bus.ram_address[8:0]] <= bus.ram_in;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (bus.ack0 || bus.ack1) begin
      if (sb.size() == 0) begin
        chk("sb_spurious_ack", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_one_ack", 32'(bus.ack0 & bus.ack1), 0);
        chk("sb_port", 32'(bus.ack1), 32'(e.port));
        if (e.rd)
          chk("sb_rdata", e.port ? bus.rdata1 : bus.rdata0, e.data);
      end
    end
  end

  task automatic set_req(input bit p, input bit r, input bit we,
                         input logic [9:0] a, input logic [15:0] d);
    if (p) begin
      bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end
  endtask

  task automatic expect_op(input bit p, input bit we,
                           input logic [9:0] a, input logic [15:0] d);
    sb.push_back('{port: p, rd: !we, data: exp_mem[a[8:0]]});
    if (we) exp_mem[a[8:0]] = d;
    lg = p;
  endtask

  // starts and ends just after a rising edge with the DUT in IDLE
  task automatic access(input bit p, input bit we,
                        input logic [9:0] a, input logic [15:0] d);
    bit ok;
    ok = 0;
    set_req(p, 1, we, a, d);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (p ? bus.gnt1 : bus.gnt0) begin
        ok = 1;
        break;
      end
    end
    chk("gnt", 32'(ok), 1);
    if (!ok) begin
      set_req(p, 0, 0, 0, 0);
      @(posedge clk); #1;
      return;
    end
    chk("gnt_other", 32'(p ? bus.gnt0 : bus.gnt1), 0);
    expect_op(p, we, a, d);
    @(posedge clk); #1;
    set_req(p, 0, 0, 0, 0);
    @(negedge clk);
    chk("acc_load", 32'(bus.ram_load), 32'(we));
    chk("acc_addr", 32'(bus.ram_address), 32'(a));
    if (we) chk("acc_ram_in", 32'(bus.ram_in), 32'(d));
    chk("acc_no_gnt", 32'(bus.gnt0 | bus.gnt1), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ack_t2", 32'(p ? bus.ack1 : bus.ack0), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_g;
    bit ok;
    int ngr;
    int last_c;
    clk = 0;
    rst_n = 0;
    mem_clr = 1;
    npass = 0;
    ntot = 0;
    lg = 1;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    for (int i = 0; i < 512; i++) exp_mem[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'({bus.gnt1, bus.gnt0}), 0);
    chk("rst_ack", 32'({bus.ack1, bus.ack0}), 0);
    chk("rst_load", 32'(bus.ram_load), 0);
    chk("rst_rdata0", 32'(bus.rdata0), 0);
    chk("rst_rdata1", 32'(bus.rdata1), 0);
    chk("rst_addr", 32'(bus.ram_address), 0);
    chk("rst_ram_in", 32'(bus.ram_in), 0);
    @(posedge clk); #1;
    mem_clr = 0;
    rst_n = 1;
    @(posedge clk); #1;

    access(0, 1, 10'h005, 16'hBEEF);
    access(1, 0, 10'h005, 16'h0000);
    chk("rdata0_hold", 32'(bus.rdata0), 0);
    chk("rdata1_hold", 32'(bus.rdata1), 32'hBEEF);
    access(0, 1, 10'h1FF, 16'h0ABC);

    // both ports held: grants every 2 cycles
`ifdef RAM512_ARB_FIXED_PRIO_EN
    exp_g = 0;
`else
    exp_g = ~lg;
`endif
    set_req(0, 1, 0, 10'h005, 0);
    set_req(1, 1, 0, 10'h1FF, 0);
    ngr = 0;
    last_c = -2;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.gnt0 || bus.gnt1) begin
        chk("rr_both", 32'(bus.gnt0 & bus.gnt1), 0);
        chk("rr_order", 32'(bus.gnt1), 32'(exp_g));
        chk("rr_spacing", c - last_c, 2);
        last_c = c;
        ngr++;
        expect_op(bus.gnt1, 0, bus.gnt1 ? 10'h1FF : 10'h005, 0);
`ifndef RAM512_ARB_FIXED_PRIO_EN
        exp_g = ~exp_g;
`endif
      end
    end
    @(posedge clk); #1;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    chk("rr_count", ngr, 6);
    repeat (3) @(posedge clk);
    #1;

    // reset in the middle of a write
    ok = 0;
    set_req(0, 1, 1, 10'h1FF, 16'h1234);
    @(negedge clk);
    ok = bus.gnt0;
    chk("rst_wr_gnt", 32'(ok), 1);
    @(posedge clk); #1;
    set_req(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_wr_load", 32'(bus.ram_load), 1);
    rst_n = 0;
    #1;
    chk("rst_load_drop", 32'(bus.ram_load), 0);
    lg = 1;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_ack", 32'(bus.ack0 | bus.ack1), 0);
    end
    @(posedge clk); #1;
    access(1, 0, 10'h1FF, 16'h0000);

    // request raised only during ACCESS is never granted
    set_req(0, 1, 1, 10'h000, 16'h1111);
    @(negedge clk);
    chk("drop_gnt0", 32'(bus.gnt0), 1);
    expect_op(0, 1, 10'h000, 16'h1111);
    @(posedge clk); #1;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 1, 0, 10'h1C0, 0);
    @(negedge clk);
    chk("drop_no_gnt", 32'(bus.gnt1), 0);
    @(posedge clk); #1;
    set_req(1, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;

    access(0, 1, 10'h1C0, 16'h2222);
    access(1, 0, 10'h000, 16'h0000);
    access(0, 0, 10'h1C0, 16'h0000);
    chk("bank_rd0", 32'(bus.rdata0), 32'h2222);
    chk("bank_rd1", 32'(bus.rdata1), 32'h1111);

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
